// File: rtl/instr_fetch.sv
// instr_fetch: MIPS front end holding the PC and fetching words over a req/ack port.
// Define IFETCH_PERF_EN to build the retired-instruction counter behind o_icount.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic [5:0]  o_Op,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid,
   input  logic        i_stall,
   input  logic        i_beq,
   input  logic        i_bne,
   input  logic        i_j,
   input  logic        i_zero,
   output logic [31:0] o_icount
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   // Word-scaled, sign-extended branch displacement.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   // Jump target keeps the region bits of the delay-slot address.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
      return {pc4[31:28], idx, 2'b00};
   endfunction

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] instr_r;
   logic        valid_r;
   logic        req_r;
   logic [31:0] pc_plus4_s;
   logic [31:0] next_pc_s;
   logic        take_br_s;
   logic        retire_s;

   assign pc_plus4_s = pc_r + 32'd4;
   assign retire_s   = (state_r == ST_VALID) && !i_stall;

   // Next-PC selection, priority j > taken branch > sequential.
   always_comb begin
      next_pc_s = pc_plus4_s;
      take_br_s = (i_beq && i_zero) || (i_bne && !i_zero);
      if (i_j) begin
         next_pc_s = jump_target(pc_plus4_s, instr_r[25:0]);
      end else if (take_br_s) begin
         next_pc_s = pc_plus4_s + branch_offset(instr_r[15:0]);
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // Fetch sequencer; req and valid are registered alongside the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         pc_r    <= {RESET_PC[31:2], 2'b00};
         instr_r <= 32'h0000_0000;
         valid_r <= 1'b0;
         req_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               req_r   <= 1'b1;
               valid_r <= 1'b0;
               state_r <= ST_FETCH;
            end
            ST_FETCH: begin
               if (i_imem_ack) begin
                  instr_r <= i_imem_rdata;
                  req_r   <= 1'b0;
                  valid_r <= 1'b1;
                  state_r <= ST_VALID;
               end else begin
                  req_r   <= 1'b1;
                  valid_r <= 1'b0;
               end
            end
            ST_VALID: begin
               if (retire_s) begin
                  pc_r    <= next_pc_s;
                  req_r   <= 1'b1;
                  valid_r <= 1'b0;
                  state_r <= ST_FETCH;
               end else begin
                  req_r   <= 1'b0;
                  valid_r <= 1'b1;
               end
            end
            default: begin
               req_r   <= 1'b0;
               valid_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] icount_r;

   // Counts every retire, wrapping at 2^32.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         icount_r <= 32'h0000_0000;
      end else if (retire_s) begin
         icount_r <= icount_r + 32'd1;
      end else begin
         icount_r <= icount_r;
      end
   end

   assign o_icount = icount_r;
`else
   assign o_icount = 32'h0000_0000;
`endif

   assign o_imem_req  = req_r;
   assign o_imem_addr = pc_r;
   assign o_instr     = instr_r;
   assign o_Op        = instr_r[31:26];
   assign o_pc        = pc_r;
   assign o_pc_plus4  = pc_plus4_s;
   assign o_valid     = valid_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/branch/jump/stall/reset vectors.
module tb_instr_fetch;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack = 1'b0;
   logic [31:0] i_imem_rdata = 32'h0000_0000;
   logic [31:0] o_instr;
   logic [5:0]  o_Op;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;
   logic        o_valid;
   logic        i_stall = 1'b0;
   logic        i_beq = 1'b0;
   logic        i_bne = 1'b0;
   logic        i_j = 1'b0;
   logic        i_zero = 1'b0;
   logic [31:0] o_icount;

`ifdef IFETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [31:0] ADDI = 32'h2008_0005;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] icount;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   retired = 0;
   logic prev_valid = 1'b0;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .o_instr(o_instr), .o_Op(o_Op), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
      .o_valid(o_valid), .i_stall(i_stall),
      .i_beq(i_beq), .i_bne(i_bne), .i_j(i_j), .i_zero(i_zero),
      .o_icount(o_icount)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] exp_icount(input int r);
      return PERF ? r[31:0] : 32'd0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: each newly presented instruction is compared with the scoreboard head.
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && !prev_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: unexpected instr %h at pc %h", o_instr, o_pc);
         end else begin
            mon_e = sb_q.pop_front();
            check("mon_pc", o_pc, mon_e.pc);
            check("mon_instr", o_instr, mon_e.instr);
            check("mon_op", {26'd0, o_Op}, {26'd0, mon_e.instr[31:26]});
            check("mon_pc_plus4", o_pc_plus4, mon_e.pc + 32'd4);
            check("mon_icount", o_icount, mon_e.icount);
         end
      end
      prev_valid = o_valid;
   end

   // One fetch: expect addr, answer after dly cycles with word, apply controls, stall stl cycles.
   task automatic do_instr(input logic [31:0] addr, input logic [31:0] word, input int dly,
                           input logic b, input logic bn, input logic jj, input logic z,
                           input int stl);
      exp_t e;
      int   n;
      e.pc = addr;
      e.instr = word;
      e.icount = exp_icount(retired);
      sb_q.push_back(e);
      n = 0;
      while (!o_imem_req && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_imem_req) begin
         total++;
         bad++;
         $display("FAIL req_timeout: no request for addr %h", addr);
      end
      check("fetch_addr", o_imem_addr, addr);
      for (int i = 0; i < dly; i++) begin
         @(negedge i_clk);
         check("req_held", {31'd0, o_imem_req}, 32'd1);
         check("addr_held", o_imem_addr, addr);
      end
      i_imem_ack = 1'b1;
      i_imem_rdata = word;
      i_beq = b;
      i_bne = bn;
      i_j = jj;
      i_zero = z;
      i_stall = (stl > 0);
      @(negedge i_clk);
      i_imem_ack = 1'b0;
      i_imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < stl; i++) begin
         @(negedge i_clk);
         check("stall_pc", o_pc, addr);
         check("stall_instr", o_instr, word);
         check("stall_req", {31'd0, o_imem_req}, 32'd0);
         check("stall_valid", {31'd0, o_valid}, 32'd1);
         check("stall_icount", o_icount, exp_icount(retired));
      end
      i_stall = 1'b0;
      retired++;
   endtask

   initial begin
      // Reset and start-up.
      repeat (3) @(negedge i_clk);
      check("rst_req", {31'd0, o_imem_req}, 32'd0);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_pc", o_pc, 32'h0000_0000);
      check("rst_instr", o_instr, 32'h0000_0000);
      check("rst_icount", o_icount, 32'h0000_0000);
      i_rst_n = 1'b1;
      #1;
      check("idle_req", {31'd0, o_imem_req}, 32'd0);
      @(negedge i_clk);
      check("start_req", {31'd0, o_imem_req}, 32'd1);
      check("start_addr", o_imem_addr, 32'h0000_0000);

      // Sequential, branch and jump vectors.
      do_instr(32'h0000_0000, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0004, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0008, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_000C, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0010, 32'h1000_FFFE,  0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      do_instr(32'h0000_000C, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0010, 32'h1000_FFFE,  0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0014, 32'h0800_0004,  0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      do_instr(32'h0000_0010, 32'h1400_FFFE,  0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      do_instr(32'h0000_000C, 32'h1400_000C,  0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      do_instr(32'h0000_0010, 32'h1000_000B,  0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      do_instr(32'h0000_0040, 32'h0800_0100,  0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
      // Wait states and stall.
      do_instr(32'h0000_0400, ADDI,           3, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      do_instr(32'h0000_0404, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Asynchronous reset in the middle of a fetch.
      @(negedge i_clk);
      check("mid_addr", o_imem_addr, 32'h0000_0408);
      @(negedge i_clk);
      check("mid_req", {31'd0, o_imem_req}, 32'd1);
      check("sb_drained", sb_q.size(), 32'd0);
      #1;
      i_rst_n = 1'b0;
      #1;
      check("arst_req", {31'd0, o_imem_req}, 32'd0);
      check("arst_valid", {31'd0, o_valid}, 32'd0);
      check("arst_pc", o_pc, 32'h0000_0000);
      check("arst_icount", o_icount, 32'h0000_0000);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_imem_ack = 1'b1;
      i_imem_rdata = 32'hBAD0_0BAD;
      retired = 0;
      @(negedge i_clk);
      i_imem_ack = 1'b0;
      check("late_ack_req", {31'd0, o_imem_req}, 32'd1);
      check("late_ack_addr", o_imem_addr, 32'h0000_0000);
      check("late_ack_valid", {31'd0, o_valid}, 32'd0);
      @(negedge i_clk);
      check("late_ack_still_fetch", {31'd0, o_valid}, 32'd0);

      // Negative branch to the top of memory, then sequential wrap to 0.
      do_instr(32'h0000_0000, 32'h1000_FFFE,  0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      do_instr(32'hFFFF_FFFC, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_instr(32'h0000_0000, ADDI,           0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge i_clk);
      check("final_icount", o_icount, exp_icount(retired));
      check("final_addr", o_imem_addr, 32'h0000_0004);
      check("final_sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
